// File: rtl/stream_reduce_sink.sv
// Stream reduction sink: consumes a valid/ready/done yielded run and reduces it
// to sum, count and maximum, then presents one held result beat downstream.
module stream_reduce_sink #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 __clock,
  input  logic                 __reset,
  input  logic                 __start,
  input  logic                 in_valid,
  input  logic                 in_done,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  input  logic                 __ready,
  output logic                 __valid,
  output logic                 __done,
  output logic [ACC_WIDTH-1:0] __output_sum,
  output logic [CNT_WIDTH-1:0] __output_count,
  output logic [WIDTH-1:0]     __output_max,
  output logic                 __output_overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  // state is the FSM register; observe it hierarchically for state checks.
  state_t state;
  state_t state_next;

  logic [ACC_WIDTH-1:0] acc_sum;
  logic [CNT_WIDTH-1:0] acc_cnt;
  logic [WIDTH-1:0]     acc_max;
  logic                 acc_ovf;

  logic                 beat;
  logic                 data_beat;
  logic                 term_beat;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 cnt_full;
  logic [WIDTH-1:0]     max_next;

  // Handshakes: an input beat moves on a rising edge where in_valid & in_ready;
  // the result moves on a rising edge where __valid & __ready. Neither side may
  // drop or change a valid beat until it has moved.
  assign in_ready  = (state == COLLECT);
  assign beat      = in_valid & in_ready;
  assign data_beat = beat & ~in_done;
  assign term_beat = beat & in_done;

  // One extra bit on the adder captures the carry-out that marks a wrap.
  assign sum_ext  = {1'b0, acc_sum} + {{(ACC_WIDTH - WIDTH + 1){1'b0}}, in_data};
  assign cnt_full = &acc_cnt;
  assign max_next = (in_data > acc_max) ? in_data : acc_max;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (__start) state_next = COLLECT;
      COLLECT: if (term_beat) state_next = EMIT;
      EMIT:    if (__ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge __clock or negedge __reset) begin
    if (!__reset) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge __clock or negedge __reset) begin
    if (!__reset) begin
      acc_sum <= '0;
      acc_cnt <= '0;
      acc_max <= '0;
      acc_ovf <= 1'b0;
    end else if (state == IDLE && __start) begin
      acc_sum <= '0;
      acc_cnt <= '0;
      acc_max <= '0;
      acc_ovf <= 1'b0;
    end else if (data_beat) begin
      acc_sum <= sum_ext[ACC_WIDTH-1:0];
      if (!cnt_full) acc_cnt <= acc_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      acc_max <= max_next;
      acc_ovf <= acc_ovf | sum_ext[ACC_WIDTH] | cnt_full;
    end
  end

  // Result registers keep their last values after the handshake.
  always_ff @(posedge __clock or negedge __reset) begin
    if (!__reset) begin
      __valid           <= 1'b0;
      __done            <= 1'b0;
      __output_sum      <= '0;
      __output_count    <= '0;
      __output_max      <= '0;
      __output_overflow <= 1'b0;
    end else if (term_beat) begin
      __valid           <= 1'b1;
      __done            <= 1'b1;
      __output_sum      <= acc_sum;
      __output_count    <= acc_cnt;
      __output_max      <= acc_max;
      __output_overflow <= acc_ovf;
    end else if (state == EMIT && __ready) begin
      __valid <= 1'b0;
      __done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_reduce_sink.sv
// Bench for stream_reduce_sink: a default-width instance and a narrow one
// (32-bit sum, 4-bit count) share stimulus and are checked against a run model.
module tb_stream_reduce_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_done = 1'b0;
  logic [31:0] in_data = '0;
  logic        res_ready = 1'b0;

  logic        in_ready_w, valid_w, done_w, ovf_w;
  logic [47:0] sum_w;
  logic [15:0] cnt_w;
  logic [31:0] max_w;
  logic        in_ready_n, valid_n, done_n, ovf_n;
  logic [31:0] sum_n;
  logic [3:0]  cnt_n;
  logic [31:0] max_n;

  always #5 clk = ~clk;

  stream_reduce_sink dut_w (
    .__clock(clk), .__reset(rst_n), .__start(start),
    .in_valid(in_valid), .in_done(in_done), .in_data(in_data), .in_ready(in_ready_w),
    .__ready(res_ready), .__valid(valid_w), .__done(done_w),
    .__output_sum(sum_w), .__output_count(cnt_w), .__output_max(max_w),
    .__output_overflow(ovf_w)
  );

  stream_reduce_sink #(.WIDTH(32), .ACC_WIDTH(32), .CNT_WIDTH(4)) dut_n (
    .__clock(clk), .__reset(rst_n), .__start(start),
    .in_valid(in_valid), .in_done(in_done), .in_data(in_data), .in_ready(in_ready_n),
    .__ready(res_ready), .__valid(valid_n), .__done(done_n),
    .__output_sum(sum_n), .__output_count(cnt_n), .__output_max(max_n),
    .__output_overflow(ovf_n)
  );

  wire [98:0] res_w = {valid_w, done_w, sum_w, cnt_w, max_w, ovf_w};
  wire [70:0] res_n = {valid_n, done_n, sum_n, cnt_n, max_n, ovf_n};

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] beats[$];

  // Reference: the run's true total, clipped to the sum/count widths.
  function automatic void fold(input int aw, input int cw, output logic [63:0] s,
                               output logic [63:0] c, output logic [63:0] m, output logic o);
    logic [63:0] tot;
    int n;
    int cmax;
    tot = 0;
    m = 0;
    n = beats.size();
    cmax = (1 << cw) - 1;
    foreach (beats[i]) begin
      tot += {32'd0, beats[i]};
      if ({32'd0, beats[i]} > m) m = {32'd0, beats[i]};
    end
    o = (tot >= (64'd1 << aw)) || (n > cmax);
    s = tot & ((64'd1 << aw) - 64'd1);
    c = (n > cmax) ? 64'(cmax) : 64'(n);
  endfunction

  function automatic logic [98:0] exp_w();
    logic [63:0] s, c, m;
    logic o;
    fold(48, 16, s, c, m, o);
    return {2'b11, s[47:0], c[15:0], m[31:0], o};
  endfunction

  function automatic logic [70:0] exp_n();
    logic [63:0] s, c, m;
    logic o;
    fold(32, 4, s, c, m, o);
    return {2'b11, s[31:0], c[3:0], m[31:0], o};
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic dn, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_done = dn;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready_w) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_done = 1'b0;
    in_data = '0;
  endtask

  task automatic push_run(input int gap_max, output bit ok);
    bit b;
    ok = 1'b1;
    foreach (beats[i]) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_beat(beats[i], 1'b0, b);
      ok &= b;
    end
    send_beat(32'd0, 1'b1, b);
    ok &= b;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (res_w !== 99'd0 || res_n !== 71'd0 || in_ready_w !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got w=%h n=%h rdy=%b exp all 0", res_w, res_n, in_ready_w);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    beats = '{32'd1, 32'd1, 32'd3, 32'd5, 32'd13};
    do_start();
    push_run(0, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL basic_accept got timeout exp all beats taken"); end
    n_vec++;
    if ({valid_w, done_w, sum_w, cnt_w, max_w, ovf_w} !== {2'b11, 48'd23, 16'd5, 32'd13, 1'b0}) begin
      n_err++;
      $display("FAIL basic_result got s=%0d c=%0d m=%0d o=%b v=%b exp 23/5/13/0/1", sum_w, cnt_w, max_w, ovf_w, valid_w);
    end
    n_vec++;
    if (res_n !== exp_n()) begin n_err++; $display("FAIL basic_narrow got %h exp %h", res_n, exp_n()); end
    take_result();
  endtask

  task automatic test_empty();
    bit ok;
    beats.delete();
    res_ready = 1'b1;
    do_start();
    push_run(0, ok);
    n_vec++;
    if (!ok || res_w !== {2'b11, 97'd0}) begin
      n_err++;
      $display("FAIL empty_result got %h ok=%b exp valid/done with zeros", res_w, ok);
    end
    @(negedge clk);
    n_vec++;
    if (valid_w !== 1'b0 || done_w !== 1'b0 || in_ready_w !== 1'b0) begin
      n_err++;
      $display("FAIL empty_one_cycle got v=%b d=%b rdy=%b exp 0/0/0", valid_w, done_w, in_ready_w);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_hold();
    bit ok;
    int bad;
    beats.delete();
    repeat (4) beats.push_back($urandom);
    do_start();
    push_run(1, ok);
    in_valid = 1'b1;
    in_data = $urandom;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (res_w !== exp_w() || res_n !== exp_n() || in_ready_w !== 1'b0) bad++;
      @(negedge clk);
    end
    n_vec++;
    if (!ok || bad != 0) begin
      n_err++;
      $display("FAIL hold_stable got %0d bad cycles ok=%b res=%h exp 0 bad, %h", bad, ok, res_w, exp_w());
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    n_vec++;
    if (valid_w !== 1'b0 || in_ready_w !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release got v=%b rdy=%b exp 0/0", valid_w, in_ready_w);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    beats = '{32'hFFFF_FFFF, 32'd2};
    do_start();
    push_run(0, ok);
    n_vec++;
    if (!ok || res_n !== {2'b11, 32'd1, 4'd2, 32'hFFFF_FFFF, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_narrow got %h ok=%b exp sum=1 cnt=2 max=ffffffff ovf=1", res_n, ok);
    end
    n_vec++;
    if (res_w !== exp_w()) begin n_err++; $display("FAIL ovf_wide got %h exp %h", res_w, exp_w()); end
    take_result();
  endtask

  task automatic test_random();
    bit ok;
    beats.delete();
    for (int i = 0; i < 100; i++)
      beats.push_back(($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom);
    do_start();
    start = 1'b1;
    push_run(3, ok);
    start = 1'b0;
    repeat ($urandom_range(0, 4)) @(negedge clk);
    n_vec++;
    if (!ok || res_w !== exp_w()) begin
      n_err++;
      $display("FAIL random_wide got %h ok=%b exp %h", res_w, ok, exp_w());
    end
    n_vec++;
    if (res_n !== exp_n()) begin n_err++; $display("FAIL random_narrow got %h exp %h", res_n, exp_n()); end
    take_result();
  endtask

  task automatic test_back_to_back();
    bit ok;
    res_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      beats.delete();
      repeat ($urandom_range(3, 8)) beats.push_back($urandom);
      do_start();
      push_run(2, ok);
      n_vec++;
      if (!ok || res_w !== exp_w() || res_n !== exp_n()) begin
        n_err++;
        $display("FAIL b2b_run%0d got %h ok=%b exp %h", r, res_w, ok, exp_w());
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int i = 0; i < 3; i++) begin
      beats = '{$urandom};
      beats.delete();
    end
    do_start();
    for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0, ok);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (res_w !== 99'd0 || res_n !== 71'd0 || in_ready_w !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid got w=%h n=%h rdy=%b exp all 0", res_w, res_n, in_ready_w);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beats = '{32'd7, 32'd9};
    do_start();
    push_run(1, ok);
    n_vec++;
    if (!ok || res_w !== {2'b11, 48'd16, 16'd2, 32'd9, 1'b0}) begin
      n_err++;
      $display("FAIL reset_clean got %h ok=%b exp sum=16 cnt=2 max=9", res_w, ok);
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_hold();
    test_overflow();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
